// File: rtl/fabric_irq_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------------------+
// | fabric_irq_ctrl: synchronises fabric IRQ lines, latches pending, drives one CPU IRQ.   |
// | Optional FABRIC_IRQ_COUNT_EN adds a saturating edge-event counter at address 4.        |
// | Revision: 1.0                                                                          |
// +---------------------------------------------------------------------------------------+
module fabric_irq_ctrl #(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [2:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  input  logic               reg_we,
  input  logic               reg_re,
  output logic [31:0]        reg_rdata,
  output logic               reg_ready,
  output logic               irq_o
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_RAW     = 3'd3;
  localparam logic [2:0] ADDR_COUNT   = 3'd4;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
  logic [NUM_IRQ-1:0] dly_q, dly_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               irq_q, irq_d;

  logic [NUM_IRQ-1:0] sync_lvl;
  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] w1c_mask;
  logic [NUM_IRQ-1:0] wr_bits;
  logic [31:0]        rd_val;
  logic               unused_wdata;

  assign sync_lvl     = sync_q[SYNC_STAGES-1];
  assign wr_bits      = reg_wdata[NUM_IRQ-1:0];
  assign unused_wdata = &{1'b0, reg_wdata};
  assign edge_set     = sync_lvl & ~dly_q & mode_q;
  assign w1c_mask     = (reg_we && reg_addr == ADDR_PENDING) ? wr_bits : '0;

  always_comb begin
    sync_d[0] = irq_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Level lines mirror the synced input; edge lines hold until W1C, and a same-cycle set wins.
  always_comb begin
    dly_d     = sync_lvl;
    pending_d = (~mode_q & sync_lvl) | (mode_q & (edge_set | (pending_q & ~w1c_mask)));
    enable_d  = (reg_we && reg_addr == ADDR_ENABLE) ? wr_bits : enable_q;
    mode_d    = (reg_we && reg_addr == ADDR_MODE)   ? wr_bits : mode_q;
    irq_d     = |(pending_q & enable_q);
  end

`ifdef FABRIC_IRQ_COUNT_EN
  logic [15:0] count_q, count_d;
  logic [5:0]  new_events;
  logic [16:0] count_sum;

  // Only 0->1 transitions of edge-mode pending bits count; the clear applies before new events.
  always_comb begin
    new_events = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      new_events = new_events + 6'(edge_set[n] & ~pending_q[n]);
    end
    count_sum = ((reg_we && reg_addr == ADDR_COUNT) ? 17'd0 : {1'b0, count_q}) + 17'(new_events);
    count_d   = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      ADDR_PENDING: rd_val = 32'(pending_q);
      ADDR_ENABLE:  rd_val = 32'(enable_q);
      ADDR_MODE:    rd_val = 32'(mode_q);
      ADDR_RAW:     rd_val = 32'(sync_lvl);
`ifdef FABRIC_IRQ_COUNT_EN
      ADDR_COUNT:   rd_val = {16'd0, count_q};
`endif
      default:      rd_val = '0;
    endcase
  end

  // A combined read+write returns zero data but still produces a single ready pulse.
  always_comb begin
    rdata_d = (reg_re && !reg_we) ? rd_val : '0;
    ready_d = reg_re | reg_we;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      dly_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      dly_q     <= dly_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      irq_q     <= irq_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign reg_ready = ready_q;
  assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_fabric_irq_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------------------+
// | tb_fabric_irq_ctrl: directed self-checking bench for fabric_irq_ctrl (4 lines, 2 sync).|
// | Revision: 1.0                                                                          |
// +---------------------------------------------------------------------------------------+
module tb_fabric_irq_ctrl;

  localparam int NUM_IRQ     = 4;
  localparam int SYNC_STAGES = 2;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [NUM_IRQ-1:0] irq_i = 4'hF;
  logic [2:0]         reg_addr = 3'd0;
  logic [31:0]        reg_wdata = 32'd0;
  logic               reg_we = 1'b0;
  logic               reg_re = 1'b0;
  logic [31:0]        reg_rdata;
  logic               reg_ready;
  logic               irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  fabric_irq_ctrl #(
    .NUM_IRQ     (NUM_IRQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .irq_i     (irq_i),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .reg_ready (reg_ready),
    .irq_o     (irq_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [31:0] data);
    reg_addr  = addr;
    reg_wdata = data;
    reg_we    = 1'b1;
    tick();
    reg_we = 1'b0;
    chk("wr_ready", 32'(reg_ready), 32'd1);
    chk("wr_rdata_zero", reg_rdata, 32'd0);
  endtask

  task automatic read_chk(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    reg_addr = addr;
    reg_re   = 1'b1;
    tick();
    reg_re = 1'b0;
    chk({tag, "_ready"}, 32'(reg_ready), 32'd1);
    chk(tag, reg_rdata, exp);
  endtask

  initial begin
    // 1: reset held with all lines high
    tick(); tick(); tick();
    chk("rst_rdata", reg_rdata, 32'd0);
    chk("rst_ready", 32'(reg_ready), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    RST = 1'b0;
    tick(); tick();
    read_chk("raw_after_sync", 3'd3, 32'hF);
    read_chk("enable_reset", 3'd1, 32'h0);
    read_chk("mode_reset", 3'd2, 32'h0);
    read_chk("pending_level_all", 3'd0, 32'hF);
    chk("irq_disabled", 32'(irq_o), 32'd0);

    // 2: level mode, latency of SYNC_STAGES+2 edges in both directions
    irq_i = 4'h0;
    tick(); tick(); tick(); tick();
    do_write(3'd1, 32'h1);
    irq_i = 4'h1;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      tick();
      chk("lvl_rise_latency", 32'(irq_o), (k == SYNC_STAGES + 2) ? 32'd1 : 32'd0);
    end
    read_chk("lvl_pending_high", 3'd0, 32'h1);
    for (int k = 0; k < 5; k++) tick();
    irq_i = 4'h0;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      tick();
      chk("lvl_fall_latency", 32'(irq_o), (k == SYNC_STAGES + 2) ? 32'd0 : 32'd1);
    end
    read_chk("lvl_pending_low", 3'd0, 32'h0);

    // 3: edge mode on line 1, latch then W1C
    do_write(3'd2, 32'h2);
    do_write(3'd1, 32'h2);
    irq_i = 4'h2;
    tick();
    irq_i = 4'h0;
    for (int k = 0; k < 5; k++) tick();
    chk("edge_irq_set", 32'(irq_o), 32'd1);
    read_chk("edge_pending_held", 3'd0, 32'h2);
    do_write(3'd0, 32'h2);
    chk("w1c_irq_edge1", 32'(irq_o), 32'd1);
    tick();
    chk("w1c_irq_edge2", 32'(irq_o), 32'd0);
    read_chk("w1c_pending_clr", 3'd0, 32'h0);

    // 4: W1C coincident with a new rising edge leaves the bit set
    irq_i = 4'h2;
    tick();
    irq_i = 4'h0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_collide_irq", 32'(irq_o), 32'd1);
    irq_i = 4'h2;
    tick(); tick();
    do_write(3'd0, 32'h2);
    chk("collide_irq_a", 32'(irq_o), 32'd1);
    tick();
    chk("collide_irq_b", 32'(irq_o), 32'd1);
    read_chk("collide_pending", 3'd0, 32'h2);
    irq_i = 4'h0;
    tick(); tick(); tick();
    do_write(3'd0, 32'h2);
    tick();
    chk("cleanup_irq", 32'(irq_o), 32'd0);

    // 5: back-to-back strobes and combined we+re
    do_write(3'd2, 32'h0);
    reg_addr = 3'd1; reg_wdata = 32'h5; reg_we = 1'b1;
    tick();
    chk("b2b_wr_ready", 32'(reg_ready), 32'd1);
    chk("b2b_wr_rdata", reg_rdata, 32'd0);
    reg_we = 1'b0; reg_re = 1'b1; reg_addr = 3'd1;
    tick();
    chk("b2b_rd1_ready", 32'(reg_ready), 32'd1);
    chk("b2b_rd_enable", reg_rdata, 32'h5);
    reg_addr = 3'd2;
    tick();
    chk("b2b_rd2_ready", 32'(reg_ready), 32'd1);
    chk("b2b_rd_mode", reg_rdata, 32'h0);
    reg_re = 1'b0;
    tick();
    chk("b2b_idle_ready", 32'(reg_ready), 32'd0);
    chk("b2b_idle_rdata", reg_rdata, 32'd0);
    reg_addr = 3'd1; reg_wdata = 32'hFFFF_FFFA; reg_we = 1'b1; reg_re = 1'b1;
    tick();
    reg_we = 1'b0; reg_re = 1'b0;
    chk("were_ready", 32'(reg_ready), 32'd1);
    chk("were_rdata", reg_rdata, 32'd0);
    tick();
    chk("were_single_pulse", 32'(reg_ready), 32'd0);
    read_chk("enable_upper_ignored", 3'd1, 32'hA);
    read_chk("addr5_zero", 3'd5, 32'h0);

    // 6: event counter at address 4
`ifdef FABRIC_IRQ_COUNT_EN
    read_chk("count_prior_events", 3'd4, 32'd2);
    do_write(3'd4, 32'h0);
    read_chk("count_cleared", 3'd4, 32'd0);
    do_write(3'd2, 32'hF);
    reg_addr = 3'd0; reg_wdata = 32'hF; reg_we = 1'b1;
    for (int i = 0; i < 36000; i++) begin
      irq_i = (i % 2 == 0) ? 4'hF : 4'h0;
      tick();
    end
    reg_we = 1'b0; irq_i = 4'h0;
    tick(); tick(); tick(); tick();
    read_chk("count_saturated", 3'd4, 32'hFFFF);
    do_write(3'd4, 32'h0);
    read_chk("count_write_clear", 3'd4, 32'd0);
`else
    do_write(3'd4, 32'h1234);
    read_chk("count_absent", 3'd4, 32'h0);
`endif

    // reset asserted while a read is in flight: no ready pulse follows
    reg_addr = 3'd1; reg_re = 1'b1;
    #2 RST = 1'b1;
    tick();
    reg_re = 1'b0;
    chk("rst_midxfer_ready", 32'(reg_ready), 32'd0);
    chk("rst_midxfer_irq", 32'(irq_o), 32'd0);
    RST = 1'b0;
    tick();
    read_chk("enable_after_rst", 3'd1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
